// File: rtl/ysyx_22040127_mem_arbiter.sv
// Two-master arbiter (instruction fetch and data) in front of one memory port.
// It allows one outstanding transaction, gives data priority, forces a fetch grant on starvation,
// and drops a fetch response that was flushed.
module ysyx_22040127_mem_arbiter #(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // instruction fetch
  input  logic              if_req_i,
  input  logic [AW-1:0]     if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DW-1:0]     if_rdata_o,
  // data side
  input  logic              d_req_i,
  input  logic              d_wen_i,
  input  logic [AW-1:0]     d_addr_i,
  input  logic [DW-1:0]     d_wdata_i,
  input  logic [DW/8-1:0]   d_wstrb_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DW-1:0]     d_rdata_o,
  // shared memory port
  output logic              mem_req_o,
  output logic              mem_wen_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        starve_q;
  logic              owner_data_q;
  logic              drop_q;
  logic              wen_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic [DW-1:0]     if_rdata_q;
  logic [DW-1:0]     d_rdata_q;

  logic starved;
  logic idle;
  logic if_win;
  logic d_win;

  // Grants are combinational; gating with rst_ni keeps them low while reset is asserted.
  assign starved = (starve_q == 4'(STARVE_MAX));
  assign idle    = rst_ni && (state_q == StIdle);
  assign if_win  = idle && if_req_i && !if_flush_i && (starved || !d_req_i);
  assign d_win   = idle && d_req_i && !if_win;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      starve_q     <= 4'd0;
      owner_data_q <= 1'b0;
      drop_q       <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (if_win) begin
        starve_q <= 4'd0;
      end else if (if_req_i && !starved) begin
        starve_q <= starve_q + 4'd1;
      end

      if ((state_q == StIssue || state_q == StWait) && !owner_data_q && if_flush_i) begin
        drop_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (if_win || d_win) begin
            state_q      <= StIssue;
            owner_data_q <= d_win;
            drop_q       <= 1'b0;
            addr_q       <= d_win ? d_addr_i : if_addr_i;
            wen_q        <= d_win && d_wen_i;
            wdata_q      <= d_win ? d_wdata_i : '0;
            wstrb_q      <= d_win ? d_wstrb_i : '0;
          end
        end
        StIssue: begin
          if (mem_ready_i) state_q <= StWait;
        end
        StWait: begin
          if (mem_rvalid_i) begin
            state_q <= StResp;
            if (owner_data_q) begin
              d_rdata_q <= mem_rdata_i;
            end else if (!drop_q && !if_flush_i) begin
              if_rdata_q <= mem_rdata_i;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt_o    = if_win;
  assign d_gnt_o     = d_win;
  assign mem_req_o   = (state_q == StIssue);
  assign mem_wen_o   = wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  // A flush arriving in the response cycle still suppresses the fetch pulse.
  assign if_rvalid_o = (state_q == StResp) && !owner_data_q && !drop_q && !if_flush_i;
  assign d_rvalid_o  = (state_q == StResp) && owner_data_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// Directed testbench for ysyx_22040127_mem_arbiter: fetch, priority, starvation, flush,
// back-pressure and reset scenarios with hand-computed expectations.
module tb_ysyx_22040127_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0]   if_addr_i;
  logic [DW-1:0]   if_rdata_o;
  logic            d_req_i, d_wen_i, d_gnt_o, d_rvalid_o;
  logic [AW-1:0]   d_addr_i;
  logic [DW-1:0]   d_wdata_i, d_rdata_o;
  logic [DW/8-1:0] d_wstrb_i;
  logic            mem_req_o, mem_wen_o, mem_ready_i, mem_rvalid_i, busy_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o, mem_rdata_i;
  logic [DW/8-1:0] mem_wstrb_o;

  int checks   = 0;
  int failures = 0;

  ysyx_22040127_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_wen_i     (d_wen_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_wstrb_i   (d_wstrb_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_wen_o   (mem_wen_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ready_i (mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called in an ISSUE cycle: ready now, response next cycle; returns in the RESP cycle.
  task automatic serve(input logic [63:0] rd);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    if_req_i = 1'b1; if_addr_i = 64'h8000_0000; if_flush_i = 1'b0;
    d_req_i = 1'b1; d_wen_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #12;
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    // Single fetch, minimum latency
    if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
    #1;
    chk("f_if_gnt", if_gnt_o, 1);
    chk("f_d_gnt", d_gnt_o, 0);
    tick();
    if_req_i = 1'b0; if_addr_i = '0;
    #1;
    chk("f_mem_req", mem_req_o, 1);
    chk("f_mem_addr", mem_addr_o, 64'h8000_0000);
    chk("f_mem_wen", mem_wen_o, 0);
    chk("f_mem_wstrb", mem_wstrb_o, 0);
    chk("f_busy1", busy_o, 1);
    serve(64'h0000_0013_0010_0073);
    chk("f_if_rvalid", if_rvalid_o, 1);
    chk("f_if_rdata", if_rdata_o, 64'h0000_0013_0010_0073);
    chk("f_busy3", busy_o, 1);
    tick();
    #1;
    chk("f_rvalid_low", if_rvalid_o, 0);
    chk("f_busy_idle", busy_o, 0);
    chk("f_rdata_hold", if_rdata_o, 64'h0000_0013_0010_0073);

    // Simultaneous request: data wins, fetch follows right after
    if_req_i = 1'b1; if_addr_i = 64'h8000_0004;
    d_req_i = 1'b1; d_wen_i = 1'b1; d_addr_i = 64'h8000_1000; d_wdata_i = 64'h55;
    d_wstrb_i = 8'h01;
    #1;
    chk("s_d_gnt", d_gnt_o, 1);
    chk("s_if_gnt", if_gnt_o, 0);
    tick();
    d_req_i = 1'b0; d_wen_i = 1'b0;
    #1;
    chk("s_mem_wen", mem_wen_o, 1);
    chk("s_mem_wstrb", mem_wstrb_o, 8'h01);
    chk("s_mem_addr", mem_addr_o, 64'h8000_1000);
    chk("s_mem_wdata", mem_wdata_o, 64'h55);
    serve(64'hAA);
    chk("s_d_rvalid", d_rvalid_o, 1);
    chk("s_d_rdata", d_rdata_o, 64'hAA);
    chk("s_if_gnt_resp", if_gnt_o, 0);
    tick();
    #1;
    chk("s_if_gnt_after", if_gnt_o, 1);
    chk("s_d_rvalid_low", d_rvalid_o, 0);
    tick();
    if_req_i = 1'b0;
    #1;
    serve(64'h1111);
    chk("s_f_rvalid", if_rvalid_o, 1);
    chk("s_f_rdata", if_rdata_o, 64'h1111);
    tick();

    // Starvation: fetch held against back-to-back data requests
    if_req_i = 1'b1; if_addr_i = 64'h8000_0008;
    d_req_i = 1'b1; d_wen_i = 1'b0; d_addr_i = 64'h8000_2000; d_wstrb_i = 8'hFF;
    #1;
    chk("st_d_gnt", d_gnt_o, 1);
    chk("st_if_gnt0", if_gnt_o, 0);
    tick();
    serve(64'h2222);
    chk("st_d_rvalid", d_rvalid_o, 1);
    tick();
    #1;
    chk("st_if_gnt", if_gnt_o, 1);
    chk("st_d_gnt_blk", d_gnt_o, 0);
    tick();
    if_req_i = 1'b0; d_req_i = 1'b0;

    // Flush during WAIT drops the fetch response
    mem_ready_i = 1'b1;
    #1;
    chk("fl_mem_addr", mem_addr_o, 64'h8000_0008);
    tick();
    mem_ready_i = 1'b0; if_flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD;
    tick();
    if_flush_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    chk("fl_busy_resp", busy_o, 1);
    chk("fl_if_rvalid", if_rvalid_o, 0);
    chk("fl_rdata_hold", if_rdata_o, 64'h1111);
    tick();
    #1;
    chk("fl_idle", busy_o, 0);

    // Flush in IDLE blocks a fetch grant but not a data grant
    if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 64'h8000_000C;
    #1;
    chk("fi_if_blocked", if_gnt_o, 0);
    d_req_i = 1'b1; d_wen_i = 1'b0;
    #1;
    chk("fi_d_gnt", d_gnt_o, 1);
    d_req_i = 1'b0;
    tick();
    if_flush_i = 1'b0;
    #1;
    chk("fi_if_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    #1;
    serve(64'h1234);
    chk("fi_if_rvalid", if_rvalid_o, 1);
    chk("fi_if_rdata", if_rdata_o, 64'h1234);
    tick();

    // Back-pressure, then reset in WAIT
    d_req_i = 1'b1; d_wen_i = 1'b0; d_addr_i = 64'h8000_3000; d_wdata_i = 64'h77;
    d_wstrb_i = 8'hFF;
    #1;
    chk("bp_d_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0; d_addr_i = 64'hFFFF_0000; d_wdata_i = 64'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_mem_req", mem_req_o, 1);
      chk("bp_mem_addr", mem_addr_o, 64'h8000_3000);
      chk("bp_mem_wdata", mem_wdata_o, 64'h77);
      tick();
    end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    chk("r_busy", busy_o, 0);
    chk("r_mem_req", mem_req_o, 0);
    chk("r_mem_addr", mem_addr_o, 0);
    chk("r_d_rdata", d_rdata_o, 0);
    chk("r_if_rdata", if_rdata_o, 0);
    tick();
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5A5A;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("r_late_d_rvalid", d_rvalid_o, 0);
    chk("r_late_busy", busy_o, 0);
    tick();
    #1;
    chk("r_late_d_rvalid2", d_rvalid_o, 0);
    chk("r_late_if_rvalid", if_rvalid_o, 0);
    chk("r_late_d_rdata", d_rdata_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
